// File: rtl/csa_add_sequencer.sv
// rtl/csa_add_sequencer.sv - nibble-serial add/subtract sequencer on one 4-bit carry-select slice
// Operands are latched on accept and consumed LSB nibble first; a registered carry links the nibbles.

module carryselectadder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] S,
    output logic       co
);
    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;

    // Upper pair is precomputed for both carries; the low pair's carry selects.
    always_comb begin
        lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
        hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
        hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
        S   = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
        co  = lo[2] ? hi1[2] : hi0[2];
    end
endmodule

module csa_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] slice_s;
    logic       slice_co;
    logic       last_nib;

    always_comb begin
        nib_a    = opa[4*idx +: 4];
        nib_b    = opb[4*idx +: 4];
        last_nib = (idx == IW'(NIB - 1));
    end

    carryselectadder u_slice (
        .a   (nib_a),
        .b   (nib_b),
        .cin (carry),
        .S   (slice_s),
        .co  (slice_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= op_sub ? ~b : b;
                        carry <= op_sub ? 1'b1 : cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[4*idx +: 4] <= slice_s;
                    carry           <= slice_co;
                    idx             <= idx + 1'b1;
                    if (last_nib) begin
                        cout  <= slice_co;
                        // opb is already inverted for subtract, so one rule covers both ops.
                        ovf   <= (opa[WIDTH-1] == opb[WIDTH-1]) && (slice_s[3] != opa[WIDTH-1]);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end
endmodule

// File: tb/tb_csa_add_sequencer.sv
// tb/tb_csa_add_sequencer.sv - scoreboard bench for csa_add_sequencer with an arithmetic reference model

module tb_csa_add_sequencer;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    csa_add_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ready_mode = 0;   // 0 random, 1 hold low, 2 hold high

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
        exp_t e;
        int   ua, ub, sa, sb, ures, sres;
        ua = int'(ta);
        ub = int'(tb);
        sa = int'($signed(ta));
        sb = int'($signed(tb));
        if (ts) begin
            ures = ua - ub;
            sres = sa - sb;
            e.co = (ua >= ub);
        end else begin
            ures = ua + ub + int'(tc);
            sres = sa + sb + int'(tc);
            e.co = (ures > 65535);
        end
        e.s   = ures[W-1:0];
        e.ov  = (sres > 32767) || (sres < -32768);
        e.acc = 0;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
        exp_t e;
        int   n;
        @(negedge clk);
        a        = ta;
        b        = tb;
        cin      = tc;
        op_sub   = ts;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e     = model(ta, tb, tc, ts);
            e.acc = cyc;
            q.push_back(e);
            in_valid = 1'b0;
            a        = W'($urandom);
            b        = W'($urandom);
            cin      = 1'($urandom);
            op_sub   = 1'($urandom);
        end
    endtask

    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic [W-1:0] held_s;
    logic         held_co;
    logic         held_ov;
    exp_t         got;

    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            check("ready_valid_exclusive", 32'(in_ready && out_valid), 32'd0);
            if (out_valid && (!pv || pr)) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    got = q.pop_front();
                    check("sum", 32'(sum), 32'(got.s));
                    check("cout", 32'(cout), 32'(got.co));
                    check("ovf", 32'(ovf), 32'(got.ov));
                    check("latency", 32'(cyc - got.acc), 32'(NIB));
                end
            end else if (out_valid && pv && !pr) begin
                check("hold_sum", 32'(sum), 32'(held_s));
                check("hold_flags", 32'({cout, ovf}), 32'({held_co, held_ov}));
            end else if (!out_valid && pv && !pr) begin
                check("out_valid_dropped", 32'(out_valid), 32'd1);
            end
            held_s  = sum;
            held_co = cout;
            held_ov = ovf;
            pv      = out_valid;
            case (ready_mode)
                1:       out_ready = 1'b0;
                2:       out_ready = 1'b1;
                default: out_ready = 1'($urandom);
            endcase
            pr = out_ready;
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'($urandom);
        a         = W'($urandom);
        b         = W'($urandom);
        cin       = 1'($urandom);
        op_sub    = 1'($urandom);
        out_ready = 1'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sum", 32'(sum), 32'h0000);
        check("reset_flags", 32'({cout, ovf}), 32'd0);

        // Directed corner cases.
        issue(16'h0006, 16'h0006, 1'b0, 1'b0);
        issue(16'h00F6, 16'h0017, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h0010, 16'h0011, 1'b1, 1'b1);
        issue(16'h8000, 16'h0001, 1'b1, 1'b1);
        wait_drain();

        // Backpressure: result held in DONE while a new request waits.
        ready_mode = 1;
        issue(16'h1357, 16'h2468, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_rise", 32'(out_valid), 32'd1);
        fork
            issue(16'hABCD, 16'h1111, 1'b1, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_out_valid_held", 32'(out_valid), 32'd1);
                    check("bp_in_ready_low", 32'(in_ready), 32'd0);
                end
                ready_mode = 2;
            end
        join
        ready_mode = 0;
        wait_drain();

        // Reset while RUN with idx==2 discards the operation.
        ready_mode = 2;
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (8) @(negedge clk);
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_drain();
        ready_mode = 0;

        // Randomized mix of adds and subtracts.
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/csa_add_sequencer.md
# csa_add_sequencer

Nibble-serial multi-word adder/subtractor controller. It accepts WIDTH-bit operands through a valid/ready handshake and processes one nibble per cycle, LSB first, on a single 4-bit carry-select adder slice. A registered carry links the nibbles. The block returns the full-width sum, carry-out and signed overflow through an output valid/ready handshake, trading latency for area wherever a wide add is needed but one 4-bit slice is budgeted.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4; NIB = WIDTH/4
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept; high only in IDLE
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for add; ignored when op_sub=1
- op_sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of bit WIDTH-1 (for subtract, 1 = no borrow)
- ovf  output  1  two's-complement overflow
- busy  output  1  high in RUN or DONE

## Operation
- Datapath: one instance of the team's 4-bit carry-select slice (carryselectadder: a[3:0], b[3:0], cin, S[3:0], co). No other adders in the block.
- Registers: opa, opb (latched, opb already inverted for subtract), carry, idx (log2(NIB) bits, min 1), sum, cout, ovf, state.
- States:
  - IDLE: in_ready=1. On in_valid: latch a; latch b or ~b; carry <= op_sub ? 1 : cin; idx <= 0; go to RUN.
  - RUN: slice inputs are opa/opb nibble idx and carry. At each edge, sum[4*idx+3:4*idx] <= S, carry <= co, idx <= idx+1. When idx==NIB-1: cout <= co, ovf <= (opa[W-1]==opb[W-1]) && (S[3]!=opa[W-1]), then go to DONE.
  - DONE: out_valid=1. On out_ready: go to IDLE.
- ovf uses the latched, possibly inverted opb, so subtract overflow is correct.
- Operand and op_sub changes after acceptance have no effect.
- in_valid is not accepted while busy. The requester holds its request until in_ready.
- sum, cout and ovf hold their last values until overwritten by the next operation. They are not cleared on accept.
- Reset: state IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, carry=0, idx=0.
- rst asserted in any state, including mid-RUN or in DONE with out_valid high, discards the operation at that edge. No out_valid pulse follows.

## Timing
- Accept edge E0 (IDLE, in_valid=1).
- Edges E1..E_NIB each write one nibble.
- out_valid rises after edge E_NIB, giving a latency of NIB cycles (4 for WIDTH=16).
- out_valid stays high and sum/cout/ovf stay stable until the edge where out_ready=1. out_valid is low the next cycle.
- If out_ready is already high when DONE is entered, DONE lasts exactly one cycle.
- The next accept can occur at the first IDLE edge. Minimum issue interval is NIB+2 cycles.
- in_ready and out_valid are mutually exclusive and both are registered-state decodes. No combinational path from in_valid or out_ready to any output.
- WIDTH=4 (NIB=1): one RUN cycle, latency 1.

## Test plan
- Reset: rst high 2 cycles with random inputs, then low. Required: in_ready=1, out_valid=0, busy=0, sum=0x0000, cout=0, ovf=0.
- Basic add, WIDTH=16: a=0x0006, b=0x0006, cin=0. Required: out_valid exactly 4 cycles after the accept edge, sum=0x000C, cout=0, ovf=0. Also a=0x00F6, b=0x0017 gives sum=0x010D.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1 gives sum=0x0000, cout=1, ovf=0. Signed overflow: a=0x7FFF, b=0x0001, cin=0 gives sum=0x8000, cout=0, ovf=1.
- Subtract: op_sub=1, cin=1 (must be ignored), a=0x0010, b=0x0011 gives sum=0xFFFF, cout=0, ovf=0. Then a=0x8000, b=0x0001 gives sum=0x7FFF, cout=1, ovf=1.
- Backpressure: out_ready low for 5 cycles in DONE, with in_valid held high and new operands applied. Required: out_valid stays 1, sum stays stable, in_ready stays 0, and no second accept happens until one IDLE cycle after out_ready.
- Reset mid-op: rst pulsed for 1 cycle while in RUN with idx=2. Required: the next cycle is IDLE with in_ready=1, and out_valid never rises for the aborted operation. A following add, a=0x1234, b=0x4321, gives sum=0x5555.
